crypto1_key_verify: RTL and testbench
=====================================

Name: crypto1_key_verify

Overview:
- Downstream consumer of the Crypto1 candidate-key cores.
- Accepts one 48-bit candidate LFSR state at a time and clocks a local Crypto1 LFSR and filter forward one bit per cycle.
- Compares the generated keystream against the captured BITSTREAM and aborts early on the first mismatch.
- Reports each surviving key through a valid/ready output handshake and keeps a count of candidates tested.

Parameters:
- NBITS, 48, number of keystream bits compared per candidate (1..48); bit i is checked against BITSTREAM[i].
- CNT_W, 32, width of the TESTED counter.

Ports:
- CLK  input  1  clock, all logic rising-edge.
- RESETn  input  1  synchronous active-low reset.
- BITSTREAM  input  48  expected keystream. Must be stable while BUSY=1.
- KEY_IN  input  48  candidate LFSR state.
- KEY_VALID  input  1  KEY_IN valid.
- KEY_READY  output  1  block can accept a candidate.
- FOUND_KEY  output  48  matched candidate, held while FOUND_VALID=1.
- FOUND_VALID  output  1  match report pending.
- FOUND_READY  input  1  consumer accepts the report.
- BUSY  output  1  state is RUN or REPORT.
- TESTED  output  CNT_W  number of candidates fully resolved (match or mismatch).

Behaviour:
- Reset (RESETn=0 at a clock edge):
  - State goes to IDLE.
  - KEY_READY=0 during the reset cycle, 1 from the first cycle after RESETn=1.
  - FOUND_VALID=0, FOUND_KEY=0, BUSY=0, TESTED=0.
  - The LFSR, bit index and saved key are cleared.
  - Reset mid-RUN or mid-REPORT abandons the candidate; it is not counted.
- State IDLE:
  - KEY_READY=1.
  - On KEY_VALID&&KEY_READY: lfsr<=KEY_IN, saved<=KEY_IN, idx<=0, go to RUN.
- State RUN:
  - KEY_READY=0.
  - Each cycle: compute z=filter(lfsr), compare z with BITSTREAM[idx], step the LFSR, idx<=idx+1.
  - On z!=BITSTREAM[idx]: TESTED+=1, go to IDLE. KEY_READY is high the next cycle.
  - On match with idx==NBITS-1: TESTED+=1, FOUND_KEY<=saved, go to REPORT.
  - Latency from acceptance to verdict:
    - a mismatch at bit k resolves k+1 cycles after acceptance;
    - a full match enters REPORT NBITS cycles after acceptance.
- State REPORT:
  - FOUND_VALID=1, KEY_READY=0.
  - FOUND_KEY stable until FOUND_VALID&&FOUND_READY, then go to IDLE.
  - FOUND_READY held high gives one report cycle. No candidate is accepted in REPORT (back-pressure to the cores).
- LFSR step:
  - State bits s[47:0].
  - fb = XOR of s at {0,5,9,10,12,14,15,17,19,24,25,27,29,35,39,41,42,43}.
  - next = {fb, s[47:1]}.
- Filter:
  - x[j]=s[2j+9] for j=0..19.
  - Nibbles n_k=x[4k+3:4k].
  - a_k = bit n_k of 16'hF22C for k=0,2,3.
  - a_k = bit n_k of 16'hD938 for k=1,4.
  - z = bit {a4,a3,a2,a1,a0} of 32'hEC57E80A (a4 is the MSB of the index).
  - Golden vectors come from the team C model.
- TESTED wraps modulo 2^CNT_W and does not saturate.
- KEY_VALID while KEY_READY=0 is ignored. The upstream holds the candidate.
- Combinational paths:
  - FOUND_READY does not combinationally drive KEY_READY. There is at least one IDLE cycle between a report and the next acceptance.
  - No combinational path from any input to any output.

Test Plan:
- Reset with all inputs 0, release RESETn -> KEY_READY=1 on the cycle after release; FOUND_VALID=0, TESTED=0, BUSY=0.
- BITSTREAM=48'h0, KEY_IN=48'h0 pulsed one cycle -> all-zero state gives z=0 every step; FOUND_VALID rises exactly 48 cycles after acceptance; FOUND_KEY=48'h0; TESTED=1.
- BITSTREAM=48'h1, KEY_IN=48'h0 -> mismatch at bit 0; back to IDLE 1 cycle after acceptance; KEY_READY=1 the next cycle; TESTED=1; FOUND_VALID never rises.
- BITSTREAM=48'h0000_0000_0080, KEY_IN=48'h0 -> mismatch at bit 7, resolved 8 cycles after acceptance; then a second candidate KEY_IN=0 with BITSTREAM=0 -> match; TESTED=2.
- Match with FOUND_READY held 0 for 10 cycles, KEY_VALID=1 throughout -> FOUND_VALID and FOUND_KEY stable and KEY_READY=0 for all 10 cycles; after the FOUND_READY pulse, IDLE then acceptance.
- Random KEY_IN/BITSTREAM against the C model over 10k candidates, including RESETn asserted mid-RUN at bit 20 -> verdicts and TESTED match the model; the aborted candidate is not counted and outputs take reset values.

Source files
------------

// File: rtl/crypto1_key_verify.sv
// crypto1_key_verify
//   Checks Crypto1 candidate keys against a captured keystream. A candidate
//   48-bit LFSR state is loaded, then the local Crypto1 LFSR and filter are
//   clocked one bit per cycle. Each generated bit is compared against
//   BITSTREAM[idx]. The candidate is dropped on the first mismatch. A
//   candidate that matches all NBITS bits is reported through a
//   valid/ready handshake.
//
// Ports
//   CLK          rising-edge clock
//   RESETn       synchronous active-low reset
//   BITSTREAM    expected keystream, bit i checked at step i (stable while BUSY)
//   KEY_IN       candidate LFSR state
//   KEY_VALID    KEY_IN valid
//   KEY_READY    block can accept a candidate (IDLE)
//   FOUND_KEY    matched candidate, held while FOUND_VALID=1
//   FOUND_VALID  match report pending (REPORT)
//   FOUND_READY  consumer accepts the report
//   BUSY         RUN or REPORT
//   TESTED       candidates fully resolved (match or mismatch), wraps
module crypto1_key_verify #(
    parameter int NBITS = 48,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic [47:0]      BITSTREAM,
    input  logic [47:0]      KEY_IN,
    input  logic             KEY_VALID,
    output logic             KEY_READY,
    output logic [47:0]      FOUND_KEY,
    output logic             FOUND_VALID,
    input  logic             FOUND_READY,
    output logic             BUSY,
    output logic [CNT_W-1:0] TESTED
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [5:0]  LAST_IDX = 6'(NBITS - 1);
    localparam logic [15:0] FILT_A   = 16'hF22C;
    localparam logic [15:0] FILT_B   = 16'hD938;
    localparam logic [31:0] FILT_C   = 32'hEC57E80A;

    state_t             state;
    state_t             state_nxt;
    logic               rdy_en;
    logic [47:0]        lfsr;
    logic [47:0]        saved;
    logic [47:0]        found_key;
    logic [5:0]         idx;
    logic [CNT_W-1:0]   tested;
    logic               bit_ok;
    logic               last_bit;
    logic               key_ready;

    // Crypto1 two-layer nonlinear filter over the odd state bits s[9..47].
    function automatic logic crypto1_filter(input logic [47:0] s);
        logic [19:0] x;
        logic [4:0]  a;
        for (int j = 0; j < 20; j++) begin
            x[j] = s[2*j + 9];
        end
        a[0] = FILT_A[x[3:0]];
        a[1] = FILT_B[x[7:4]];
        a[2] = FILT_A[x[11:8]];
        a[3] = FILT_A[x[15:12]];
        a[4] = FILT_B[x[19:16]];
        return FILT_C[a];
    endfunction

    // Shift towards bit 0; feedback enters at bit 47.
    function automatic logic [47:0] crypto1_step(input logic [47:0] s);
        logic fb;
        fb = s[0]  ^ s[5]  ^ s[9]  ^ s[10] ^ s[12] ^ s[14] ^
             s[15] ^ s[17] ^ s[19] ^ s[24] ^ s[25] ^ s[27] ^
             s[29] ^ s[35] ^ s[39] ^ s[41] ^ s[42] ^ s[43];
        return {fb, s[47:1]};
    endfunction

    assign bit_ok   = (crypto1_filter(lfsr) == BITSTREAM[idx]);
    assign last_bit = (idx == LAST_IDX);

    // State register
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (KEY_VALID && rdy_en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!bit_ok) begin
                    state_nxt = IDLE;
                end else if (last_bit) begin
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                if (FOUND_READY) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode from registered state only, so no input reaches an
    // output combinationally. rdy_en holds KEY_READY low in the reset cycle.
    always_comb begin
        key_ready   = 1'b0;
        FOUND_VALID = 1'b0;
        BUSY        = 1'b0;
        case (state)
            IDLE:    key_ready   = rdy_en;
            RUN:     BUSY        = 1'b1;
            REPORT: begin
                FOUND_VALID = 1'b1;
                BUSY        = 1'b1;
            end
            default: key_ready   = 1'b0;
        endcase
    end

    assign KEY_READY = key_ready;
    assign FOUND_KEY = found_key;
    assign TESTED    = tested;

    // Datapath: LFSR, bit index, saved candidate, report key, counter
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            rdy_en    <= 1'b0;
            lfsr      <= '0;
            saved     <= '0;
            found_key <= '0;
            idx       <= '0;
            tested    <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (key_ready && KEY_VALID) begin
                lfsr  <= KEY_IN;
                saved <= KEY_IN;
                idx   <= '0;
            end else if (state == RUN) begin
                lfsr <= crypto1_step(lfsr);
                idx  <= idx + 6'd1;
                if (!bit_ok || last_bit) begin
                    tested <= tested + CNT_W'(1);
                end
                if (bit_ok && last_bit) begin
                    found_key <= saved;
                end
            end
        end
    end

endmodule

// File: tb/tb_crypto1_key_verify.sv
// tb_crypto1_key_verify
//   Directed and model-driven checks of crypto1_key_verify: reset values,
//   match/mismatch latency, report back-pressure, and random candidates
//   including a reset that abandons a candidate mid-run.
module tb_crypto1_key_verify;

    localparam int NBITS = 48;
    localparam int CNT_W = 32;
    localparam int TAPS[18] = '{0, 5, 9, 10, 12, 14, 15, 17, 19, 24, 25, 27, 29, 35, 39, 41, 42, 43};

    logic             CLK;
    logic             RESETn;
    logic [47:0]      BITSTREAM;
    logic [47:0]      KEY_IN;
    logic             KEY_VALID;
    logic             KEY_READY;
    logic [47:0]      FOUND_KEY;
    logic             FOUND_VALID;
    logic             FOUND_READY;
    logic             BUSY;
    logic [CNT_W-1:0] TESTED;

    int errors = 0;
    int checks = 0;

    crypto1_key_verify #(.NBITS(NBITS), .CNT_W(CNT_W)) dut (
        .CLK         (CLK),
        .RESETn      (RESETn),
        .BITSTREAM   (BITSTREAM),
        .KEY_IN      (KEY_IN),
        .KEY_VALID   (KEY_VALID),
        .KEY_READY   (KEY_READY),
        .FOUND_KEY   (FOUND_KEY),
        .FOUND_VALID (FOUND_VALID),
        .FOUND_READY (FOUND_READY),
        .BUSY        (BUSY),
        .TESTED      (TESTED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model
    function automatic logic m_filter(input logic [47:0] s);
        logic [15:0] ta;
        logic [15:0] tb;
        logic [31:0] tc;
        logic [3:0]  n0, n1, n2, n3, n4;
        logic [4:0]  a;
        ta = 16'hF22C;
        tb = 16'hD938;
        tc = 32'hEC57E80A;
        n0 = {s[15], s[13], s[11], s[9]};
        n1 = {s[23], s[21], s[19], s[17]};
        n2 = {s[31], s[29], s[27], s[25]};
        n3 = {s[39], s[37], s[35], s[33]};
        n4 = {s[47], s[45], s[43], s[41]};
        a  = {tb[n4], ta[n3], ta[n2], tb[n1], ta[n0]};
        return tc[a];
    endfunction

    function automatic logic [47:0] m_step(input logic [47:0] s);
        logic [47:0] mask;
        mask = '0;
        for (int t = 0; t < 18; t++) mask[TAPS[t]] = 1'b1;
        return {^(s & mask), s[47:1]};
    endfunction

    function automatic logic [47:0] m_keystream(input logic [47:0] key);
        logic [47:0] s;
        logic [47:0] ks;
        s  = key;
        ks = '0;
        for (int i = 0; i < NBITS; i++) begin
            ks[i] = m_filter(s);
            s     = m_step(s);
        end
        return ks;
    endfunction

    task automatic wait_clk();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESETn      = 1'b0;
        KEY_VALID   = 1'b0;
        FOUND_READY = 1'b0;
        wait_clk();
        wait_clk();
        RESETn = 1'b1;
        wait_clk();
    endtask

    // Present one candidate and count cycles after acceptance until the
    // block either reports a match or drops back to IDLE (bounded).
    task automatic run_cand(input logic [47:0] key, input logic [47:0] bs,
                            output int lat, output logic found);
        KEY_IN    = key;
        BITSTREAM = bs;
        KEY_VALID = 1'b1;
        wait_clk();
        KEY_VALID = 1'b0;
        lat   = 0;
        found = 1'b0;
        while (lat < 60) begin
            wait_clk();
            lat++;
            if (FOUND_VALID) begin
                found = 1'b1;
                break;
            end
            if (!BUSY) break;
        end
    endtask

    task automatic release_report();
        FOUND_READY = 1'b1;
        wait_clk();
        FOUND_READY = 1'b0;
    endtask

    task automatic test_reset();
        RESETn      = 1'b0;
        BITSTREAM   = '0;
        KEY_IN      = '0;
        KEY_VALID   = 1'b0;
        FOUND_READY = 1'b0;
        repeat (3) wait_clk();
        checks++;
        if (KEY_READY !== 1'b0) begin errors++; $display("FAIL reset_key_ready got=%b exp=0", KEY_READY); end
        checks++;
        if (BUSY !== 1'b0 || FOUND_VALID !== 1'b0) begin
            errors++; $display("FAIL reset_busy_valid got=%b%b exp=00", BUSY, FOUND_VALID);
        end
        checks++;
        if (TESTED !== '0 || FOUND_KEY !== '0) begin
            errors++; $display("FAIL reset_counts tested=%0d key=%h exp=0/0", TESTED, FOUND_KEY);
        end
        RESETn = 1'b1;
        wait_clk();
        checks++;
        if (KEY_READY !== 1'b1) begin errors++; $display("FAIL release_key_ready got=%b exp=1", KEY_READY); end
    endtask

    task automatic test_zero_match();
        int   lat;
        logic found;
        do_reset();
        FOUND_READY = 1'b1;
        run_cand(48'h0, 48'h0, lat, found);
        checks++;
        if (!found || lat != 48) begin errors++; $display("FAIL zero_match_latency found=%b lat=%0d exp=1/48", found, lat); end
        checks++;
        if (FOUND_KEY !== 48'h0 || TESTED !== 32'd1 || KEY_READY !== 1'b0) begin
            errors++; $display("FAIL zero_match_report key=%h tested=%0d rdy=%b exp=0/1/0", FOUND_KEY, TESTED, KEY_READY);
        end
        wait_clk();
        FOUND_READY = 1'b0;
        checks++;
        if (FOUND_VALID !== 1'b0 || KEY_READY !== 1'b1) begin
            errors++; $display("FAIL zero_match_one_report valid=%b rdy=%b exp=0/1", FOUND_VALID, KEY_READY);
        end
    endtask

    task automatic test_mismatch_bit0();
        int   lat;
        logic found;
        do_reset();
        run_cand(48'h0, 48'h1, lat, found);
        checks++;
        if (found || lat != 1) begin errors++; $display("FAIL mismatch0_latency found=%b lat=%0d exp=0/1", found, lat); end
        checks++;
        if (KEY_READY !== 1'b1 || TESTED !== 32'd1) begin
            errors++; $display("FAIL mismatch0_idle rdy=%b tested=%0d exp=1/1", KEY_READY, TESTED);
        end
        wait_clk();
        checks++;
        if (FOUND_VALID !== 1'b0 || BUSY !== 1'b0) begin
            errors++; $display("FAIL mismatch0_quiet valid=%b busy=%b exp=0/0", FOUND_VALID, BUSY);
        end
    endtask

    task automatic test_mismatch_bit7();
        int   lat;
        logic found;
        do_reset();
        run_cand(48'h0, 48'h0000_0000_0080, lat, found);
        checks++;
        if (found || lat != 8) begin errors++; $display("FAIL mismatch7_latency found=%b lat=%0d exp=0/8", found, lat); end
        run_cand(48'h0, 48'h0, lat, found);
        checks++;
        if (!found || lat != 48) begin errors++; $display("FAIL mismatch7_second found=%b lat=%0d exp=1/48", found, lat); end
        checks++;
        if (TESTED !== 32'd2) begin errors++; $display("FAIL mismatch7_tested got=%0d exp=2", TESTED); end
        release_report();
    endtask

    task automatic test_backpressure();
        int   lat;
        logic found;
        do_reset();
        run_cand(48'h0, 48'h0, lat, found);
        checks++;
        if (!found) begin errors++; $display("FAIL bp_enter_report found=%b exp=1", found); end
        KEY_IN      = 48'h1234_5678_9ABC;
        KEY_VALID   = 1'b1;
        FOUND_READY = 1'b0;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (FOUND_VALID !== 1'b1 || FOUND_KEY !== 48'h0 || KEY_READY !== 1'b0) begin
                errors++; $display("FAIL bp_hold cyc=%0d valid=%b key=%h rdy=%b exp=1/0/0", c, FOUND_VALID, FOUND_KEY, KEY_READY);
            end
            wait_clk();
        end
        release_report();
        checks++;
        if (FOUND_VALID !== 1'b0 || KEY_READY !== 1'b1 || BUSY !== 1'b0) begin
            errors++; $display("FAIL bp_idle valid=%b rdy=%b busy=%b exp=0/1/0", FOUND_VALID, KEY_READY, BUSY);
        end
        wait_clk();
        KEY_VALID = 1'b0;
        checks++;
        if (BUSY !== 1'b1 || KEY_READY !== 1'b0) begin
            errors++; $display("FAIL bp_accept busy=%b rdy=%b exp=1/0", BUSY, KEY_READY);
        end
        lat = 0;
        while (BUSY && lat < 60) begin
            if (FOUND_VALID) FOUND_READY = 1'b1;
            wait_clk();
            lat++;
        end
        FOUND_READY = 1'b0;
        checks++;
        if (BUSY !== 1'b0 || TESTED !== 32'd2) begin
            errors++; $display("FAIL bp_drain busy=%b tested=%0d exp=0/2", BUSY, TESTED);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [47:0] key;
        key = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
        KEY_IN    = key;
        BITSTREAM = m_keystream(key);
        KEY_VALID = 1'b1;
        wait_clk();
        KEY_VALID = 1'b0;
        repeat (20) wait_clk();
        checks++;
        if (BUSY !== 1'b1 || FOUND_VALID !== 1'b0) begin
            errors++; $display("FAIL midrun_busy busy=%b valid=%b exp=1/0", BUSY, FOUND_VALID);
        end
        RESETn = 1'b0;
        wait_clk();
        checks++;
        if (BUSY !== 1'b0 || FOUND_VALID !== 1'b0 || KEY_READY !== 1'b0 || TESTED !== '0 || FOUND_KEY !== '0) begin
            errors++; $display("FAIL midrun_reset busy=%b valid=%b rdy=%b tested=%0d key=%h exp=0/0/0/0/0",
                               BUSY, FOUND_VALID, KEY_READY, TESTED, FOUND_KEY);
        end
        RESETn = 1'b1;
        wait_clk();
        checks++;
        if (KEY_READY !== 1'b1 || TESTED !== '0) begin
            errors++; $display("FAIL midrun_release rdy=%b tested=%0d exp=1/0", KEY_READY, TESTED);
        end
    endtask

    task automatic test_random();
        logic [47:0] key;
        logic [47:0] ks;
        logic [47:0] bs;
        int          r;
        int          k;
        int          exp_lat;
        int          lat;
        logic        found;
        int          tested_m;
        do_reset();
        tested_m = 0;
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                test_reset_mid_run();
                tested_m = 0;
            end
            key = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
            ks  = m_keystream(key);
            r   = $urandom_range(0, 127);
            if (r == 0)      bs = ks;
            else if (r < 5)  bs = ks ^ (48'h1 << $urandom_range(0, 47));
            else             bs = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
            k = NBITS;
            for (int b = NBITS - 1; b >= 0; b--) if (ks[b] != bs[b]) k = b;
            exp_lat = (k < NBITS) ? k + 1 : NBITS;
            run_cand(key, bs, lat, found);
            tested_m++;
            checks++;
            if (lat != exp_lat || found != (k == NBITS)) begin
                errors++; $display("FAIL rand_verdict i=%0d key=%h lat=%0d found=%b exp=%0d/%b", i, key, lat, found, exp_lat, (k == NBITS));
            end
            if (found) begin
                checks++;
                if (FOUND_KEY !== key) begin errors++; $display("FAIL rand_found_key i=%0d got=%h exp=%h", i, FOUND_KEY, key); end
                release_report();
            end
            if ((i % 1000) == 999) begin
                checks++;
                if (TESTED !== CNT_W'(tested_m)) begin errors++; $display("FAIL rand_tested i=%0d got=%0d exp=%0d", i, TESTED, tested_m); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_match();
        test_mismatch_bit0();
        test_mismatch_bit7();
        test_backpressure();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
